// File: rtl/fifo_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_param_if
//   Bundle of handshake, address and status signals between the circular
//   buffer controller and its producer/consumer/buffer-memory side.
//
//   master : producer/consumer side (drives flush, wr_valid, rd_ready)
//   slave  : controller side (drives readiness, strobes, addresses, status)
//
//   flush        synchronous clear of pointers and count
//   wr_valid     producer offers a write beat
//   wr_ready     controller accepts a write beat
//   wen          buffer write strobe
//   waddr        base address of the write beat
//   rd_ready     consumer takes a read beat
//   rd_valid     a read beat is available
//   raddr        base address of the read beat
//   count        occupancy in words
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
// ---------------------------------------------------------------------------
interface fifo_ctrl_param_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5
);
    logic              flush;
    logic              wr_valid;
    logic              wr_ready;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic              rd_ready;
    logic              rd_valid;
    logic [ADDR_W-1:0] raddr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;

    modport master (
        output flush, wr_valid, rd_ready,
        input  wr_ready, wen, waddr, rd_valid, raddr,
               count, full, empty, almost_full, almost_empty
    );

    modport slave (
        input  flush, wr_valid, rd_ready,
        output wr_ready, wen, waddr, rd_valid, raddr,
               count, full, empty, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_ctrl_param.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_param
//   Pointer/occupancy controller for an external multi-word circular buffer.
//   Each write beat stores PAR_WRITE words at waddr, each read beat removes
//   PAR_READ words from raddr. A write and a read may complete in the same
//   cycle. DEPTH need not be a power of two; it must be a multiple of both
//   PAR_WRITE and PAR_READ so a beat never straddles the wrap point.
//
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fifo_ctrl_param_if.slave (handshakes, addresses, status flags)
// ---------------------------------------------------------------------------
module fifo_ctrl_param #(
    parameter int DEPTH     = 16,
    parameter int PAR_WRITE = 1,
    parameter int PAR_READ  = 1,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_ctrl_param_if.slave      bus
);

    // Count-domain constants
    localparam logic [CNT_W-1:0] C_WR_LIMIT = CNT_W'(DEPTH - PAR_WRITE);
    localparam logic [CNT_W-1:0] C_PW       = CNT_W'(PAR_WRITE);
    localparam logic [CNT_W-1:0] C_PR       = CNT_W'(PAR_READ);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF       = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] C_AE       = CNT_W'(AE_THRESH);

    // Pointer-domain constants, one bit wider so ptr + P cannot overflow
    localparam logic [ADDR_W:0]  P_PW       = (ADDR_W + 1)'(PAR_WRITE);
    localparam logic [ADDR_W:0]  P_PR       = (ADDR_W + 1)'(PAR_READ);
    localparam logic [ADDR_W:0]  P_DEPTH    = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_wr_ready;
    logic              w_rd_valid;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [ADDR_W:0]   w_wptr_sum;
    logic [ADDR_W:0]   w_rptr_sum;
    logic [ADDR_W-1:0] w_wptr_next;
    logic [ADDR_W-1:0] w_rptr_next;
    logic [CNT_W-1:0]  w_count_next;

    // Readiness looks only at the registered count, never at the other
    // handshake, so there is no combinational path from rd_ready to wr_ready.
    // rst_n gates both so nothing handshakes while reset is held, even though
    // the cleared count would otherwise make wr_ready look true.
    assign w_wr_ready = rst_n && !bus.flush && (r_count <= C_WR_LIMIT);
    assign w_rd_valid = rst_n && !bus.flush && (r_count >= C_PR);

    assign w_wr_fire  = bus.wr_valid && w_wr_ready;
    assign w_rd_fire  = bus.rd_ready && w_rd_valid;

    // Modular advance: DEPTH may be non-power-of-two, so wrap explicitly
    // instead of relying on natural truncation of the pointer width.
    assign w_wptr_sum  = {1'b0, r_wptr} + P_PW;
    assign w_rptr_sum  = {1'b0, r_rptr} + P_PR;
    assign w_wptr_next = (w_wptr_sum >= P_DEPTH) ? ADDR_W'(w_wptr_sum - P_DEPTH)
                                                 : ADDR_W'(w_wptr_sum);
    assign w_rptr_next = (w_rptr_sum >= P_DEPTH) ? ADDR_W'(w_rptr_sum - P_DEPTH)
                                                 : ADDR_W'(w_rptr_sum);

    // Result always lies in 0..DEPTH, so modular CNT_W arithmetic is exact.
    assign w_count_next = r_count
                        + (w_wr_fire ? C_PW : '0)
                        - (w_rd_fire ? C_PR : '0);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_fire) r_wptr <= w_wptr_next;
            if (w_rd_fire) r_rptr <= w_rptr_next;
            r_count <= w_count_next;
        end
    end

    assign bus.wr_ready     = w_wr_ready;
    assign bus.rd_valid     = w_rd_valid;
    assign bus.wen          = w_wr_fire;
    assign bus.waddr        = r_wptr;
    assign bus.raddr        = r_rptr;
    assign bus.count        = r_count;

    // Flags decode from the count register only: valid the cycle after the edge
    assign bus.full         = (r_count == C_DEPTH);
    assign bus.empty        = (r_count == '0);
    assign bus.almost_full  = (r_count >= C_AF);
    assign bus.almost_empty = (r_count <= C_AE);

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl_param
//   Directed bench for fifo_ctrl_param with DEPTH=6, PAR_WRITE=2,
//   PAR_READ=3, AF_THRESH=4, AE_THRESH=1. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl_param;

    localparam int DEPTH  = 6;
    localparam int PW     = 2;
    localparam int PR     = 3;
    localparam int AF     = 4;
    localparam int AE     = 1;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    fifo_ctrl_param_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    fifo_ctrl_param #(
        .DEPTH     (DEPTH),
        .PAR_WRITE (PW),
        .PAR_READ  (PR),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int cnt, input int wa,
                                input int ra, input int f, input int e,
                                input int af, input int ae);
        check({tag, "_count"}, int'(bus.count), cnt);
        check({tag, "_waddr"}, int'(bus.waddr), wa);
        check({tag, "_raddr"}, int'(bus.raddr), ra);
        check({tag, "_full"},  int'(bus.full), f);
        check({tag, "_empty"}, int'(bus.empty), e);
        check({tag, "_af"},    int'(bus.almost_full), af);
        check({tag, "_ae"},    int'(bus.almost_empty), ae);
    endtask

    task automatic write_beat(input string tag, input int exp_waddr);
        bus.wr_valid = 1'b1;
        #1;
        check({tag, "_wen"},   int'(bus.wen), 1);
        check({tag, "_waddr"}, int'(bus.waddr), exp_waddr);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_beat(input string tag, input int exp_raddr);
        bus.rd_ready = 1'b1;
        #1;
        check({tag, "_rd_valid"}, int'(bus.rd_valid), 1);
        check({tag, "_raddr"},    int'(bus.raddr), exp_raddr);
        tick();
        bus.rd_ready = 1'b0;
    endtask

    // Structural invariants sampled on the falling edge while out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            check("inv_count_le_depth", int'(bus.count <= CNT_W'(DEPTH)), 1);
            check("inv_ptr_diff",
                  (int'(bus.waddr) - int'(bus.raddr) + DEPTH) % DEPTH,
                  int'(bus.count) % DEPTH);
            check("inv_wen_when_full", int'(bus.wen & bus.full), 0);
            check("inv_read_underflow",
                  int'(bus.rd_valid & bus.rd_ready & (bus.count < CNT_W'(PR))), 0);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int fill_waddr [3] = '{0, 2, 4};
        int fill_count [3] = '{2, 4, 6};
        int fill_af    [3] = '{0, 1, 1};
        int fill_full  [3] = '{0, 0, 1};

        bus.flush    = 1'b0;
        bus.wr_valid = 1'b1;   // offered during reset: must not strobe
        bus.rd_ready = 1'b0;

        // ---------------- reset state ----------------
        #2;
        expect_state("rst", 0, 0, 0, 0, 1, 0, 1);
        check("rst_wr_ready", int'(bus.wr_ready), 0);
        check("rst_rd_valid", int'(bus.rd_valid), 0);
        check("rst_wen",      int'(bus.wen), 0);
        bus.wr_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_wr_ready", int'(bus.wr_ready), 1);
        check("rel_rd_valid", int'(bus.rd_valid), 0);

        // ---------------- fill ----------------
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            #1;
            check("fill_wr_ready", int'(bus.wr_ready), 1);
            check("fill_wen",      int'(bus.wen), 1);
            check("fill_waddr",    int'(bus.waddr), fill_waddr[i]);
            tick();
            check("fill_count", int'(bus.count), fill_count[i]);
            check("fill_af",    int'(bus.almost_full), fill_af[i]);
            check("fill_full",  int'(bus.full), fill_full[i]);
        end
        check("full_wr_ready", int'(bus.wr_ready), 0);
        check("full_rd_valid", int'(bus.rd_valid), 1);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("hold_wen", int'(bus.wen), 0);
            tick();
            check("hold_count", int'(bus.count), 6);
        end
        bus.wr_valid = 1'b0;
        expect_state("filled", 6, 0, 0, 1, 0, 1, 0);

        // ---------------- drain ----------------
        read_beat("drain0", 0);
        check("drain0_count", int'(bus.count), 3);
        read_beat("drain1", 3);
        bus.rd_ready = 1'b1;
        #1;
        check("drained_rd_valid", int'(bus.rd_valid), 0);
        bus.rd_ready = 1'b0;
        expect_state("drained", 0, 0, 0, 0, 1, 0, 1);

        // ---------------- simultaneous with write wrap ----------------
        write_beat("pre_sim0", 0);
        write_beat("pre_sim1", 2);
        expect_state("pre_sim", 4, 4, 0, 0, 0, 1, 0);
        bus.wr_valid = 1'b1;
        bus.rd_ready = 1'b1;
        #1;
        check("sim_wen",      int'(bus.wen), 1);
        check("sim_waddr",    int'(bus.waddr), 4);
        check("sim_rd_valid", int'(bus.rd_valid), 1);
        check("sim_raddr",    int'(bus.raddr), 0);
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        expect_state("post_sim", 3, 0, 3, 0, 0, 0, 0);

        // next write lands at the wrapped address 0
        write_beat("wrap_wr", 0);
        expect_state("wrap_wr", 5, 2, 3, 0, 0, 1, 0);
        check("count5_wr_ready", int'(bus.wr_ready), 0);
        read_beat("wrap_rd", 3);
        expect_state("wrap_rd", 2, 2, 0, 0, 0, 0, 0);
        write_beat("refill0", 2);
        write_beat("refill1", 4);
        expect_state("refill", 6, 0, 0, 1, 0, 1, 0);

        // ---------------- consumer stall ----------------
        for (int i = 0; i < 5; i++) begin
            check("stall_rd_valid", int'(bus.rd_valid), 1);
            check("stall_raddr",    int'(bus.raddr), 0);
            check("stall_count",    int'(bus.count), 6);
            tick();
        end

        // ---------------- full with read in progress: no bypass ----------------
        bus.wr_valid = 1'b1;
        bus.rd_ready = 1'b1;
        #1;
        check("nobypass_wr_ready", int'(bus.wr_ready), 0);
        check("nobypass_wen",      int'(bus.wen), 0);
        check("nobypass_rd_valid", int'(bus.rd_valid), 1);
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        expect_state("nobypass", 3, 0, 3, 0, 0, 0, 0);

        // ---------------- flush ----------------
        write_beat("pre_fl0", 0);
        read_beat("pre_fl1", 3);
        write_beat("pre_fl2", 2);
        expect_state("pre_flush", 4, 4, 0, 0, 0, 1, 0);
        bus.wr_valid = 1'b1;
        bus.rd_ready = 1'b1;
        bus.flush    = 1'b1;
        #1;
        check("flush_wen",      int'(bus.wen), 0);
        check("flush_rd_valid", int'(bus.rd_valid), 0);
        check("flush_wr_ready", int'(bus.wr_ready), 0);
        tick();
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        #1;
        expect_state("post_flush", 0, 0, 0, 0, 1, 0, 1);
        check("post_flush_wr_ready", int'(bus.wr_ready), 1);

        // ---------------- async reset mid-cycle ----------------
        write_beat("pre_rst0", 0);
        write_beat("pre_rst1", 2);
        check("pre_rst_count", int'(bus.count), 4);
        bus.wr_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count",    int'(bus.count), 0);
        check("arst_empty",    int'(bus.empty), 1);
        check("arst_wr_ready", int'(bus.wr_ready), 0);
        check("arst_wen",      int'(bus.wen), 0);
        check("arst_rd_valid", int'(bus.rd_valid), 0);
        check("arst_waddr",    int'(bus.waddr), 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("arel_wr_ready", int'(bus.wr_ready), 1);
        check("arel_wen",      int'(bus.wen), 1);
        check("arel_waddr",    int'(bus.waddr), 0);
        tick();
        bus.wr_valid = 1'b0;
        expect_state("arel_wr", 2, 2, 0, 0, 0, 0, 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
